bank_sram_arb: RTL

BANK_SRAM_ARB -- requirements
Module: bank_sram_arb

---
 rtl/bank_pkg.sv | 38 +++
 rtl/bank_sram_arb_prio.sv | 42 ++++
 rtl/bank_sram_arb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the banked SRAM arbiter: opcodes, FSM states, request
// sources and the latched request record.
package bank_pkg;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_READ_LF = 2'd2;
  localparam logic [1:0] OP_WB      = 2'd3;

  localparam logic SRC_IQ = 1'b0;
  localparam logic SRC_LF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

  typedef struct packed {
    logic       src;
    logic [1:0] op;
    logic [5:0] line;
    logic       offset;
    logic [7:0] wbuf_id;
    logic [2:0] rob;
    logic [1:0] ch;
  } req_t;

  // Linefill, read-with-linefill and write-back each move a whole two-beat line.
  function automatic logic is_double(input req_t r);
    return (r.src == SRC_LF) || (r.op == OP_READ_LF) || (r.op == OP_WB);
  endfunction

  function automatic logic is_write(input req_t r);
    return (r.src == SRC_LF) || (r.op == OP_WRITE);
  endfunction

endpackage

// File: rtl/bank_sram_arb_prio.sv
// Grant selection between issue-queue and linefill requesters; linefill has
// fixed priority. BANK_SRAM_ARB_STARVE_EN adds a starvation counter for iq.
module bank_sram_arb_prio #(
  parameter int STARVE_MAX = 4
) (
`ifdef BANK_SRAM_ARB_STARVE_EN
  input  logic clk_i,
  input  logic rst_i,
`endif
  input  logic i_arb_en,
  input  logic i_iq_valid,
  input  logic i_lf_valid,
  output logic o_grant_iq,
  output logic o_grant_lf
);

`ifdef BANK_SRAM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force_iq;

  assign w_force_iq = (r_starve_cnt == CNT_W'(STARVE_MAX));
  assign o_grant_iq = i_arb_en && i_iq_valid && (!i_lf_valid || w_force_iq);

  // Counts consecutive arbitrations iq lost to linefill; saturates at the limit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (o_grant_iq) begin
      r_starve_cnt <= '0;
    end else if (i_iq_valid && o_grant_lf && !w_force_iq) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign o_grant_iq = i_arb_en && i_iq_valid && !i_lf_valid;
`endif

  assign o_grant_lf = i_arb_en && i_lf_valid && !o_grant_iq;

endmodule

// File: rtl/bank_sram_arb.sv
// Banked SRAM port arbiter: issue-queue vs linefill, one- or two-beat SRAM
// accesses with a registered read-response pipe. Option: BANK_SRAM_ARB_STARVE_EN.
module bank_sram_arb
  import bank_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       iq_sc_valid_i,
  output logic       iq_sc_ready_o,
  input  logic [2:0] iq_sc_opcode_i,
  input  logic [6:0] iq_sc_set_way_offset_i,
  input  logic [7:0] iq_sc_wbuffer_id_i,
  input  logic [2:0] iq_sc_xbar_rob_num_i,
  input  logic [1:0] iq_sc_channel_id_i,
  input  logic       lf_valid_i,
  output logic       lf_ready_o,
  input  logic [5:0] lf_set_way_i,
  output logic       sram_cen_o,
  output logic       sram_wen_o,
  output logic [6:0] sram_addr_o,
  output logic       sram_wsel_o,
  output logic [7:0] wbuf_rd_id_o,
  output logic       rsp_valid_o,
  output logic [2:0] rsp_rob_num_o,
  output logic [1:0] rsp_channel_o,
  output logic       rsp_last_o,
  output logic       rsp_evict_o
);

  state_e     r_state;
  req_t       r_req;
  req_t       w_new_req;
  logic       w_arb_en;
  logic       w_grant_iq;
  logic       w_grant_lf;
  logic       w_unused_opcode_msb;

  assign w_unused_opcode_msb = iq_sc_opcode_i[2];
  assign w_arb_en            = (r_state == ST_IDLE) && !rst_i;
  assign iq_sc_ready_o       = w_grant_iq;
  assign lf_ready_o          = w_grant_lf;

  bank_sram_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
`ifdef BANK_SRAM_ARB_STARVE_EN
    .clk_i      (clk_i),
    .rst_i      (rst_i),
`endif
    .i_arb_en   (w_arb_en),
    .i_iq_valid (iq_sc_valid_i),
    .i_lf_valid (lf_valid_i),
    .o_grant_iq (w_grant_iq),
    .o_grant_lf (w_grant_lf)
  );

  // NOTE: every field gets a default first so no path leaves w_new_req latched.
  always_comb begin
    w_new_req = '0;
    if (w_grant_lf) begin
      w_new_req.src  = SRC_LF;
      w_new_req.line = lf_set_way_i;
    end else begin
      w_new_req.src     = SRC_IQ;
      w_new_req.op      = iq_sc_opcode_i[1:0];
      w_new_req.line    = iq_sc_set_way_offset_i[6:1];
      w_new_req.offset  = iq_sc_set_way_offset_i[0];
      w_new_req.wbuf_id = iq_sc_wbuffer_id_i;
      w_new_req.rob     = iq_sc_xbar_rob_num_i;
      w_new_req.ch      = iq_sc_channel_id_i;
    end
  end

  // NOTE: all state and outputs use non-blocking assignments so every register
  // samples the pre-edge values; SRAM and response outputs are registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_req         <= '0;
      sram_cen_o    <= 1'b0;
      sram_wen_o    <= 1'b0;
      sram_addr_o   <= '0;
      sram_wsel_o   <= 1'b0;
      wbuf_rd_id_o  <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rob_num_o <= '0;
      rsp_channel_o <= '0;
      rsp_last_o    <= 1'b0;
      rsp_evict_o   <= 1'b0;
    end else begin
      // A read beat on the SRAM this cycle returns its data one cycle later.
      if (sram_cen_o && !sram_wen_o) begin
        rsp_valid_o   <= 1'b1;
        rsp_rob_num_o <= r_req.rob;
        rsp_channel_o <= r_req.ch;
        rsp_last_o    <= (r_state == ST_BEAT1) || !is_double(r_req);
        rsp_evict_o   <= (r_req.src == SRC_IQ) && (r_req.op == OP_WB);
      end else begin
        rsp_valid_o   <= 1'b0;
        rsp_rob_num_o <= '0;
        rsp_channel_o <= '0;
        rsp_last_o    <= 1'b0;
        rsp_evict_o   <= 1'b0;
      end

      sram_cen_o   <= 1'b0;
      sram_wen_o   <= 1'b0;
      sram_addr_o  <= '0;
      sram_wsel_o  <= 1'b0;
      wbuf_rd_id_o <= '0;

      case (r_state)
        ST_IDLE: begin
          if (w_grant_iq || w_grant_lf) begin
            r_req        <= w_new_req;
            r_state      <= ST_BEAT0;
            sram_cen_o   <= 1'b1;
            sram_wen_o   <= is_write(w_new_req);
            sram_wsel_o  <= (w_new_req.src == SRC_LF);
            sram_addr_o  <= is_double(w_new_req) ? {w_new_req.line, 1'b0}
                                                 : {w_new_req.line, w_new_req.offset};
            wbuf_rd_id_o <= ((w_new_req.src == SRC_IQ) && (w_new_req.op == OP_WRITE))
                            ? w_new_req.wbuf_id : 8'd0;
          end
        end
        ST_BEAT0: begin
          if (is_double(r_req)) begin
            r_state     <= ST_BEAT1;
            sram_cen_o  <= 1'b1;
            sram_wen_o  <= is_write(r_req);
            sram_wsel_o <= (r_req.src == SRC_LF);
            sram_addr_o <= {r_req.line, 1'b1};
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
